// File: rtl/coax_rx_fifo.sv
// coax_rx_fifo: 3270 coax biphase receiver. It frames messages, checks the parity of
// each word and buffers the decoded words in a first-word fall-through FIFO.
module coax_rx_fifo #(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int DATA_WIDTH     = 10,
  parameter int DEPTH          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  parity,
  input  logic                  rd,
  input  logic                  clear_status,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last,
  output logic                  parity_error,
  output logic                  empty,
  output logic                  full,
  output logic                  active,
  output logic                  overflow,
  output logic                  error
);

  localparam int CW = $clog2(2 * CLOCKS_PER_BIT + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int EW = DATA_WIDTH + 2;

  localparam logic [CW-1:0] MID_LO  = CW'((3 * CLOCKS_PER_BIT) / 4);
  localparam logic [CW-1:0] MID_HI  = CW'((5 * CLOCKS_PER_BIT) / 4);
  localparam logic [CW-1:0] VIO_LO  = CW'((5 * CLOCKS_PER_BIT) / 4);
  localparam logic [CW-1:0] VIO_HI  = CW'((7 * CLOCKS_PER_BIT) / 4);
  localparam logic [CW-1:0] CNT_MAX = CW'(2 * CLOCKS_PER_BIT);
  localparam logic [CW-1:0] SYNC_PH = CW'(CLOCKS_PER_BIT / 2 + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_QUIESCE   = 3'd1;
  localparam logic [2:0] S_VIOLATION = 3'd2;
  localparam logic [2:0] S_SYNC      = 3'd3;
  localparam logic [2:0] S_DATA      = 3'd4;
  localparam logic [2:0] S_PARITY    = 3'd5;

  logic rx_s1, rx_s2, rx_s3;
  logic line, line_edge;

  // NOTE: all sequential state uses non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1 <= 1'b0;
      rx_s2 <= 1'b0;
      rx_s3 <= 1'b0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign line      = rx_s2;
  assign line_edge = rx_s2 ^ rx_s3;

  logic [2:0]            state;
  logic [2:0]            ones;
  logic                  vio_high;
  logic [CW-1:0]         phase, since_edge;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  pend_valid, pend_perr;
  logic [DATA_WIDTH-1:0] pend_data;
  logic                  mid_edge, timeout, vio_ok;
  logic                  commit, commit_last, abort;

  // phase counts cycles since the last mid-bit transition; since_edge counts cycles since any transition
  assign mid_edge = line_edge && (phase >= MID_LO) && (phase <= MID_HI);
  assign timeout  = phase > MID_HI;
  assign vio_ok   = (since_edge >= VIO_LO) && (since_edge <= VIO_HI);

  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    commit      = 1'b0;
    commit_last = 1'b0;
    abort       = 1'b0;
    if (state == S_SYNC) begin
      if (timeout) begin
        if (line) begin
          commit      = pend_valid;
          commit_last = 1'b1;
        end else begin
          abort = 1'b1;
        end
      end else if (mid_edge) begin
        if (line) commit = pend_valid;
        else      abort  = 1'b1;
      end
    end else if ((state == S_DATA || state == S_PARITY) && timeout) begin
      abort = 1'b1;
    end
  end

  logic [AW:0]   wr_ptr, rd_ptr;
  logic          do_rd, do_wr, drop;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd && !empty;
  assign do_wr = commit && (!full || do_rd);
  assign drop  = commit && full && !do_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ones       <= 3'd0;
      vio_high   <= 1'b0;
      phase      <= CNT_MAX;
      since_edge <= CNT_MAX;
      bit_cnt    <= '0;
      shift      <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_perr  <= 1'b0;
      active     <= 1'b0;
      overflow   <= 1'b0;
      error      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      since_edge <= line_edge ? CW'(1) : (since_edge == CNT_MAX) ? since_edge : since_edge + 1'b1;
      phase      <= mid_edge  ? CW'(1) : (phase == CNT_MAX) ? phase : phase + 1'b1;
      overflow   <= (overflow && !clear_status) || drop;
      error      <= (error && !clear_status) || abort;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;

      case (state)
        S_IDLE: begin
          if (line_edge && line) begin
            state <= S_QUIESCE;
            ones  <= 3'd1;
            phase <= CW'(1);
          end
        end
        S_QUIESCE: begin
          if (timeout) begin
            if (ones >= 3'd5 && !line) begin
              state    <= S_VIOLATION;
              vio_high <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else if (mid_edge) begin
            if (!line)              state <= S_IDLE;
            else if (ones != 3'd5)  ones  <= ones + 1'b1;
          end
        end
        S_VIOLATION: begin
          if (since_edge > VIO_HI) begin
            state <= S_IDLE;
          end else if (line_edge) begin
            if (!vio_ok) begin
              state <= S_IDLE;
            end else if (!vio_high) begin
              vio_high <= 1'b1;
            end else begin
              // the sync bit's mid-bit transition is due half a bit after this falling edge
              state <= S_SYNC;
              phase <= SYNC_PH;
            end
          end
        end
        S_SYNC: begin
          if (timeout || (mid_edge && !line)) begin
            state      <= S_IDLE;
            active     <= 1'b0;
            pend_valid <= 1'b0;
          end else if (mid_edge) begin
            state      <= S_DATA;
            active     <= 1'b1;
            bit_cnt    <= '0;
            pend_valid <= 1'b0;
          end
        end
        S_DATA: begin
          if (timeout) begin
            state      <= S_IDLE;
            active     <= 1'b0;
            pend_valid <= 1'b0;
          end else if (mid_edge) begin
            shift <= {shift[DATA_WIDTH-2:0], line};
            if (bit_cnt == BW'(DATA_WIDTH - 1)) state   <= S_PARITY;
            else                                bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (timeout) begin
            state      <= S_IDLE;
            active     <= 1'b0;
            pend_valid <= 1'b0;
          end else if (mid_edge) begin
            pend_valid <= 1'b1;
            pend_data  <= shift;
            pend_perr  <= (^{shift, line}) != parity;
            state      <= S_SYNC;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the storage array is not reset; the empty flag gates the outputs, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= {pend_data, commit_last, pend_perr};
  end

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign {data, last, parity_error} = head;

endmodule

// File: tb/tb_coax_rx_fifo.sv
// Testbench for coax_rx_fifo: drives biphase messages onto rx. A scoreboard queue
// receives the expected words, and a monitor pops the FIFO and compares each entry.
`timescale 1ns/1ps
module tb_coax_rx_fifo;
  localparam int CPB = 8;
  localparam int DW  = 10;
  localparam logic [2:0] ST_IDLE = 3'd0;

  logic clk = 1'b0;
  logic reset, rx, parity, rd, clear_status;
  logic reset4, rd4, clear4;
  logic [DW-1:0] data, data4;
  logic last, parity_error, empty, full, active, overflow, error;
  logic last4, perr4, empty4, full4, active4, ovf4, err4;

  always #5 clk = ~clk;

  coax_rx_fifo #(.CLOCKS_PER_BIT(CPB), .DATA_WIDTH(DW), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .rx(rx), .parity(parity), .rd(rd),
    .clear_status(clear_status), .data(data), .last(last),
    .parity_error(parity_error), .empty(empty), .full(full), .active(active),
    .overflow(overflow), .error(error)
  );

  coax_rx_fifo #(.CLOCKS_PER_BIT(CPB), .DATA_WIDTH(DW), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset4), .rx(rx), .parity(parity), .rd(rd4),
    .clear_status(clear4), .data(data4), .last(last4),
    .parity_error(perr4), .empty(empty4), .full(full4), .active(active4),
    .overflow(ovf4), .error(err4)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic          p;
  } entry_t;

  entry_t        sb[$];
  int            checks = 0;
  int            errors = 0;
  bit            mon_en = 1'b0;
  logic [DW-1:0] msg [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: whenever the FIFO presents an entry, compare it with the scoreboard head and pop it
  initial begin : monitor
    entry_t e;
    rd = 1'b0;
    forever begin
      @(negedge clk);
      rd = 1'b0;
      if (mon_en && !empty) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got data %0h last %0b, expected no entry", data, last);
        end else begin
          e = sb.pop_front();
          check("sb_data", 32'(data), 32'(e.d));
          check("sb_last", 32'(last), 32'(e.l));
          check("sb_perr", 32'(parity_error), 32'(e.p));
        end
        rd = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic b, input bit no_mid);
    drive(~b, CPB / 2);
    drive(no_mid ? ~b : b, CPB / 2);
  endtask

  // One message from msg[0..n-1]. The task stops at (cut_w, cut_b). If cut_stop is set it
  // returns there; otherwise it first sends that bit without its mid-bit transition.
  task automatic send_msg(input int n, input logic [7:0] bad, input int cut_w, input int cut_b,
                          input bit cut_stop, input bit push);
    logic pb;
    drive(1'b1, 4 * CPB);
    repeat (5) send_bit(1'b1, 1'b0);
    drive(1'b0, 3 * CPB / 2);
    drive(1'b1, 3 * CPB / 2);
    for (int i = 0; i < n; i++) begin
      if (push && i > 0) sb.push_back(entry_t'{msg[i-1], 1'b0, bad[i-1]});
      send_bit(1'b1, 1'b0);
      for (int b = DW - 1; b >= 0; b--) begin
        if (i == cut_w && (DW - 1 - b) == cut_b) begin
          if (!cut_stop) send_bit(msg[i][b], 1'b1);
          return;
        end
        send_bit(msg[i][b], 1'b0);
        if (i == 0 && b == DW - 3) begin
          #1;
          check("active_mid", 32'(active), 1);
        end
      end
      pb = (^msg[i]) ^ parity ^ bad[i];
      send_bit(pb, 1'b0);
    end
    if (push) sb.push_back(entry_t'{msg[n-1], 1'b1, bad[n-1]});
    drive(1'b1, 3 * CPB);
  endtask

  task automatic settle(input string tag);
    repeat (64) @(posedge clk);
    @(negedge clk);
    check({tag, "_drained"}, sb.size(), 0);
    check({tag, "_active"}, 32'(active), 0);
    check({tag, "_idle"}, 32'(dut.state), 32'(ST_IDLE));
    check({tag, "_empty"}, 32'(empty), 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"}, 32'(data), 0);
    check({tag, "_last"}, 32'(last), 0);
    check({tag, "_perr"}, 32'(parity_error), 0);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_full"}, 32'(full), 0);
    check({tag, "_active"}, 32'(active), 0);
    check({tag, "_overflow"}, 32'(overflow), 0);
    check({tag, "_error"}, 32'(error), 0);
  endtask

  initial begin : stimulus
    reset = 1'b1; reset4 = 1'b1; rx = 1'b1; parity = 1'b0;
    clear_status = 1'b0; rd4 = 1'b0; clear4 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0; reset4 = 1'b0;
    mon_en = 1'b1;

    // Single word 0x00A with even parity
    msg[0] = 10'h00A;
    send_msg(1, 8'h00, -1, 0, 1'b0, 1'b1);
    settle("t1");
    check("t1_error", 32'(error), 0);

    // Three words, odd parity
    parity = 1'b1;
    msg[0] = 10'h3FF; msg[1] = 10'h000; msg[2] = 10'h155;
    send_msg(3, 8'h00, -1, 0, 1'b0, 1'b1);
    settle("t2");
    check("t2_error", 32'(error), 0);

    // Second word with a bad parity bit, even parity
    parity = 1'b0;
    msg[0] = 10'h2A5; msg[1] = 10'h0F0; msg[2] = 10'h301;
    send_msg(3, 8'b010, -1, 0, 1'b0, 1'b1);
    settle("t3");
    check("t3_error", 32'(error), 0);

    // Overflow on the DEPTH=4 instance; the main instance drains normally
    reset4 = 1'b1;
    @(negedge clk);
    reset4 = 1'b0;
    check("t4_rst_empty", 32'(empty4), 1);
    msg[0] = 10'h111; msg[1] = 10'h222; msg[2] = 10'h333;
    msg[3] = 10'h044; msg[4] = 10'h155; msg[5] = 10'h266;
    send_msg(6, 8'h00, -1, 0, 1'b0, 1'b1);
    settle("t4");
    check("t4_full4", 32'(full4), 1);
    check("t4_ovf4", 32'(ovf4), 1);
    check("t4_main_ovf", 32'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      check("t4_data4", 32'(data4), 32'(msg[i]));
      check("t4_last4", 32'(last4), 0);
      rd4 = 1'b1;
      @(posedge clk);
      #1 rd4 = 1'b0;
      @(negedge clk);
    end
    check("t4_empty4", 32'(empty4), 1);
    check("t4_notfull4", 32'(full4), 0);
    check("t4_ovf4_held", 32'(ovf4), 1);
    clear4 = 1'b1;
    @(posedge clk);
    #1 clear4 = 1'b0;
    @(negedge clk);
    check("t4_ovf4_clr", 32'(ovf4), 0);

    // Mid-bit transition removed in DATA of word 2
    msg[0] = 10'h2AB; msg[1] = 10'h155; msg[2] = 10'h0CC;
    send_msg(3, 8'h00, 1, 4, 1'b0, 1'b1);
    drive(1'b1, 3 * CPB);
    settle("t5");
    check("t5_error", 32'(error), 1);
    clear_status = 1'b1;
    @(posedge clk);
    #1 clear_status = 1'b0;
    @(negedge clk);
    check("t5_error_clr", 32'(error), 0);

    // Reset during DATA of word 2, then a clean single-word message
    mon_en = 1'b0;
    msg[0] = 10'h3C3; msg[1] = 10'h0A5;
    send_msg(2, 8'h00, 1, 3, 1'b1, 1'b0);
    #1;
    check("t6_pre_active", 32'(active), 1);
    check("t6_pre_empty", 32'(empty), 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("t6_rst");
    check("t6_rst_idle", 32'(dut.state), 32'(ST_IDLE));
    reset = 1'b0;
    mon_en = 1'b1;
    msg[0] = 10'h12D;
    send_msg(1, 8'h00, -1, 0, 1'b0, 1'b1);
    settle("t6");
    check("t6_error", 32'(error), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coax_rx_fifo.md
# coax_rx_fifo

Parametrised 3270 coax receiver: decodes the biphase line, frames messages, checks per-word parity and buffers decoded words in an internal FIFO with end-of-message and error tagging. Successor to `coax_rx`, generalised in bit rate, word width and buffer depth. Adds multi-word message buffering, per-word status, overflow detection and error reporting. Sits between the line input synchroniser and the host-side register/SPI interface.

## Interface
- `CLOCKS_PER_BIT`, 8: `clk` cycles per line bit cell; even, ≥ 8.
- `DATA_WIDTH`, 10: data bits per word.
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `rx`  in  1  asynchronous coax line input (internally double-flopped)
- `parity`  in  1  0 = even, 1 = odd parity over {data, parity bit}
- `rd`  in  1  pop the head entry; ignored when `empty`
- `clear_status`  in  1  clears `overflow` and `error`
- `data`  out  DATA_WIDTH  head entry data (first-word fall-through)
- `last`  out  1  head entry is the final word of its message
- `parity_error`  out  1  head entry failed parity
- `empty`  out  1  FIFO empty
- `full`  out  1  FIFO holds DEPTH entries
- `active`  out  1  message reception in progress
- `overflow`  out  1  sticky: a word was dropped because the FIFO was full
- `error`  out  1  sticky: message aborted by a line violation

## Operation
- Decode: a transition within [¾, 1¼]·CLOCKS_PER_BIT cycles of the previous mid-bit transition is a mid-bit transition; it restarts the phase counter. Rising = '1', falling = '0'. Transitions near ½ bit are bit-boundary transitions and are ignored. No mid-bit transition by 1¼·CLOCKS_PER_BIT is a *timeout*.
- States:
  - IDLE: wait for a '1' mid-bit transition → QUIESCE (count = 1).
  - QUIESCE: count consecutive '1's; a '0' or timeout before count 5 → IDLE; on timeout after ≥ 5 ones with line low → VIOLATION.
  - VIOLATION: line low then high, each 1½ bits (±¼ bit); any other shape → IDLE, no error.
  - SYNC: expect '1' (sync bit) → DATA; set `active`.
  - DATA: shift DATA_WIDTH bits, MSB first → PARITY.
  - PARITY: capture parity bit, hold word as *pending* → SYNC.
  - In SYNC, timeout with line high → end of message: commit pending word with `last = 1`, → IDLE, clear `active`.
  - In SYNC, a '0' bit, or timeout in DATA/PARITY → abort: discard pending and partial words, set `error`, → IDLE.
- Pending word is committed with `last = 0` on the sync bit of the next word. Every message therefore ends with a `last = 1` entry unless aborted; an aborted message's earlier committed words stay in the FIFO.
- `parity_error` = ^{data, parity bit} ≠ `parity`.
- Commit with FIFO full: word dropped, `overflow` set. Commit and `rd` in the same cycle while full: pop then write, no drop.
- `clear_status` and a new set event in the same cycle: flag stays set.

## Timing
- Reset values: `data` 0, `last` 0, `parity_error` 0, `empty` 1, `full` 0, `active` 0, `overflow` 0, `error` 0; state IDLE; FIFO pointers 0.
- Reset mid-message: all of the above in the cycle after `reset` is sampled high; pending word lost.
- `rx` to decoder: 2-cycle synchroniser plus 1-cycle edge detect.
- Commit: entry visible (`empty` low, `data` valid) 1 cycle after the committing sync-bit transition or end timeout.
- `rd` sampled high: next entry (or `empty` = 1) presented the following cycle.
- `active` rises the cycle after the first sync bit decodes; falls with the end commit or abort.

## Test plan
- Single word 10'b0000001010, parity valid, CLOCKS_PER_BIT = 8 → one entry: data 0x00A, last 1, parity_error 0; `active` low, state IDLE 64 cycles after line idles.
- Three words 0x3FF, 0x000, 0x155 → three entries in order, last = 0, 0, 1; `empty` after three `rd`s.
- Second word with bad parity → entry 2 parity_error 1, others 0; `error` stays 0.
- DEPTH = 4, six-word message, no reads → `full` 1, `overflow` 1, entries are words 1–4; `clear_status` → `overflow` 0.
- Mid-bit transition removed in DATA of word 2 → word 1 in FIFO with last 0, word 2 absent, `error` 1, state IDLE.
- `reset` asserted during DATA of word 2 → all outputs at reset values next cycle; following clean one-word message received correctly.
